smartnic_250mhz_pkt_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares one 512-bit AXI-S egress between NUM_IN AXI-S ingress streams.
- Typical use: merging host H2C traffic and adapter RX traffic into a single C2H/TX path in the 250 MHz application region.
- Provides a registered output stage, per-input enables driven from the register block, and per-input packet counters for status.

---
 rtl/smartnic_250mhz_pkt_arb.sv | 155 +++++++++++++++
 tb/tb_smartnic_250mhz_pkt_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smartnic_250mhz_pkt_arb.sv
// Packet-atomic round-robin arbiter: merges NUM_IN AXI-S ingress streams onto
// one registered AXI-S egress. Once a multi-beat packet starts, its input stays
// locked until tlast so packets never interleave.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet in flight; grant picked round-robin among enabled
// BUSY  | multi-beat packet in flight from input 'lock'; others blocked
module smartnic_250mhz_pkt_arb #(
   parameter int NUM_IN        = 2,
   parameter int DATA_BYTE_WID = 64,
   parameter int TUSER_WID     = 48
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_IN-1:0]               s_tvalid,
   output logic [NUM_IN-1:0]               s_tready,
   input  logic [NUM_IN*DATA_BYTE_WID*8-1:0] s_tdata,
   input  logic [NUM_IN*DATA_BYTE_WID-1:0] s_tkeep,
   input  logic [NUM_IN-1:0]               s_tlast,
   input  logic [NUM_IN*TUSER_WID-1:0]     s_tuser,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic [DATA_BYTE_WID*8-1:0]      m_tdata,
   output logic [DATA_BYTE_WID-1:0]        m_tkeep,
   output logic                            m_tlast,
   output logic [TUSER_WID-1:0]            m_tuser,
   output logic [2:0]                      m_tid,
   input  logic [NUM_IN-1:0]               in_enable,
   output logic [NUM_IN*32-1:0]            pkt_cnt,
   output logic                            busy
);

   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int DW    = DATA_BYTE_WID * 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]   lock, lock_nxt;
   logic [IDX_W-1:0]   grant, sel;
   logic               grant_vld, sel_vld;
   logic               stage_ready, accept, sel_last;
   logic [NUM_IN-1:0]  req, ready_int;
   logic [NUM_IN*32-1:0] cnt_q;

   assign stage_ready = !m_tvalid || m_tready;
   assign req         = s_tvalid & in_enable;
   assign busy        = (state == BUSY);
   assign pkt_cnt     = cnt_q;

   // Round-robin search starting just after the last winner; the nearest
   // requester is visited last so it overrides farther ones.
   always_comb begin : grant_search
      logic [IDX_W-1:0] idx;
      idx       = '0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = NUM_IN; k >= 1; k--) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_IN);
         if (req[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

   // Select the serving input and open only its ready; while BUSY the locked
   // input is served regardless of its enable so the packet always completes.
   always_comb begin
      sel       = (state == BUSY) ? lock : grant;
      sel_vld   = (state == BUSY) || grant_vld;
      ready_int = '0;
      if (sel_vld) ready_int[sel] = stage_ready;
      accept    = sel_vld && stage_ready && s_tvalid[sel];
      sel_last  = s_tlast[sel];
   end

   // Ready is held low while reset is asserted.
   assign s_tready = aresetn ? ready_int : '0;

   // Next-state, round-robin pointer and lock update.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      lock_nxt   = lock;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sel_last) begin
                  rr_ptr_nxt = grant;
               end else begin
                  lock_nxt  = grant;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (accept && sel_last) begin
               rr_ptr_nxt = lock;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration state registers; rr_ptr starts at the last input so input 0 wins first.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= IDLE;
         rr_ptr <= IDX_W'(NUM_IN - 1);
         lock   <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         lock   <= lock_nxt;
      end
   end

   // Egress register stage: load on accept, drop valid once the beat is taken.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tlast  <= 1'b0;
         m_tuser  <= '0;
         m_tid    <= '0;
      end else if (accept) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata[sel*DW +: DW];
         m_tkeep  <= s_tkeep[sel*DATA_BYTE_WID +: DATA_BYTE_WID];
         m_tlast  <= sel_last;
         m_tuser  <= s_tuser[sel*TUSER_WID +: TUSER_WID];
         m_tid    <= 3'(sel);
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

   // Per-input packet counters, bumped when a tlast beat is accepted (wrapping).
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else if (accept && sel_last) begin
         cnt_q[sel*32 +: 32] <= cnt_q[sel*32 +: 32] + 32'd1;
      end
   end

endmodule

// File: tb/tb_smartnic_250mhz_pkt_arb.sv
// Bench for smartnic_250mhz_pkt_arb: packet-level round-robin model produces the
// expected egress beat stream; a compare process checks every egress cycle.
module tb_smartnic_250mhz_pkt_arb;
   localparam int N  = 2;
   localparam int DB = 64;
   localparam int DW = 512;
   localparam int TU = 48;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic [N-1:0]    s_tvalid, s_tready, s_tlast, in_enable;
   logic [N*DW-1:0] s_tdata;
   logic [N*DB-1:0] s_tkeep;
   logic [N*TU-1:0] s_tuser;
   logic            m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]   m_tdata;
   logic [DB-1:0]   m_tkeep;
   logic [TU-1:0]   m_tuser;
   logic [2:0]      m_tid;
   logic [N*32-1:0] pkt_cnt;
   logic            busy;

   smartnic_250mhz_pkt_arb #(.NUM_IN(N), .DATA_BYTE_WID(DB), .TUSER_WID(TU)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
      .in_enable(in_enable), .pkt_cnt(pkt_cnt), .busy(busy)
   );

   always #2 aclk = ~aclk;

   typedef struct {
      logic [DW-1:0] data;
      logic [DB-1:0] keep;
      logic          last;
      logic [TU-1:0] user;
      logic [2:0]    tid;
   } beat_t;

   beat_t       src_q[N][$];
   beat_t       exp_q[$];
   bit          tr_pat[$];
   int          tid_log[$];
   logic [31:0] exp_cnt[N];
   int          m_rr;
   bit          in_pkt;
   bit [N-1:0]  fire;
   bit          chk_en = 1'b0;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int beats_seen, valid_cycles, busy_cycles, stall_cnt, first_cyc, last_cyc;
   bit tready1_seen;
   bit prev_stall;
   logic [DW-1:0]  held_data;
   logic [115:0]   held_side;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   task automatic clear_stats();
      beats_seen   = 0;
      valid_cycles = 0;
      busy_cycles  = 0;
      stall_cnt    = 0;
      first_cyc    = -1;
      last_cyc     = -1;
      tready1_seen = 1'b0;
      prev_stall   = 1'b0;
      tid_log.delete();
   endtask

   // Queue one packet on input i; content encodes tag and beat index.
   task automatic load_pkt(input int i, input int len, input int tag);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {16{32'(tag * 256 + k)}};
         b.last = (k == len - 1);
         b.keep = b.last ? ({DB{1'b1}} >> (tag % 8)) : {DB{1'b1}};
         b.user = TU'(tag * 16 + i);
         b.tid  = 3'(i);
         src_q[i].push_back(b);
      end
   endtask

   // Packet-level round robin over everything queued: after the last winner,
   // take the next enabled input holding a packet, emit that whole packet.
   task automatic plan(input logic [N-1:0] en);
      int    pos[N];
      int    pick;
      bit    found;
      beat_t b;
      for (int i = 0; i < N; i++) pos[i] = 0;
      for (int p = 0; p < 64; p++) begin
         found = 1'b0;
         pick  = 0;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!found && en[j] && pos[j] < src_q[j].size()) begin
               found = 1'b1;
               pick  = j;
            end
         end
         if (!found) break;
         do begin
            b = src_q[pick][pos[pick]];
            pos[pick]++;
            exp_q.push_back(b);
         end while (!b.last);
         m_rr = pick;
         exp_cnt[pick] = exp_cnt[pick] + 32'd1;
      end
   endtask

   task automatic do_reset();
      chk_en  = 1'b0;
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_cnt[i] = '0;
      end
      exp_q.delete();
      tr_pat.delete();
      s_tvalid = '0;
      m_rr     = N - 1;
      in_pkt   = 1'b0;
      fire     = '0;
      repeat (2) step();
      aresetn = 1'b1;
      clear_stats();
      chk_en = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
         step();
         n++;
      end
      check({name, "_drain_left"}, exp_q.size(), 0);
      check({name, "_drain_vld"}, m_tvalid, 1'b0);
   endtask

   task automatic check_counts(input string name);
      for (int i = 0; i < N; i++)
         check({name, "_pkt_cnt"}, pkt_cnt[i*32 +: 32], exp_cnt[i]);
   endtask

   task automatic drive_inputs();
      beat_t b;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_tvalid[i]             = 1'b1;
            s_tdata[i*DW +: DW]     = b.data;
            s_tkeep[i*DB +: DB]     = b.keep;
            s_tlast[i]              = b.last;
            s_tuser[i*TU +: TU]     = b.user;
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
         end
      end
      m_tready = (tr_pat.size() > 0) ? tr_pat.pop_front() : 1'b1;
   endtask

   // Source/sink driver: note handshakes before the edge, retire them after it.
   initial begin
      beat_t b;
      forever begin
         @(negedge aclk);
         for (int i = 0; i < N; i++) fire[i] = s_tvalid[i] & s_tready[i];
         @(posedge aclk);
         #1;
         if (aresetn) begin
            for (int i = 0; i < N; i++) begin
               if (fire[i] && src_q[i].size() > 0) begin
                  b = src_q[i].pop_front();
                  in_pkt = !b.last;
               end
            end
         end
         drive_inputs();
      end
   end

   // Compare process: egress beats against the model, plus per-cycle rules.
   always @(negedge aclk) begin
      beat_t b;
      cyc++;
      if (chk_en && aresetn) begin
         if (prev_stall) begin
            check("hold_data", m_tdata, held_data);
            check("hold_side", {m_tkeep, m_tlast, m_tuser, m_tid}, held_side);
         end
         if (m_tvalid && !m_tready) begin
            check("stall_rdy", s_tready, '0);
            stall_cnt++;
         end
         check("busy", busy, in_pkt);
         check("rdy_onehot", ($countones(s_tready) <= 1), 1'b1);
         for (int i = 0; i < N; i++)
            if (!busy && !in_enable[i]) check("dis_rdy", s_tready[i], 1'b0);
         if (s_tready[1]) tready1_seen = 1'b1;
         if (m_tvalid) valid_cycles++;
         if (busy) busy_cycles++;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1'b1, 1'b0);
            end else begin
               b = exp_q.pop_front();
               check("beat_data", m_tdata, b.data);
               check("beat_side", {m_tkeep, m_tlast, m_tuser, m_tid}, {b.keep, b.last, b.user, b.tid});
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            beats_seen++;
            tid_log.push_back(int'(m_tid));
         end
         prev_stall = m_tvalid && !m_tready;
         held_data  = m_tdata;
         held_side  = {m_tkeep, m_tlast, m_tuser, m_tid};
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      s_tvalid  = '0;
      s_tdata   = '0;
      s_tkeep   = '0;
      s_tlast   = '0;
      s_tuser   = '0;
      m_tready  = 1'b1;
      in_enable = 2'b11;
      #1;
      check("rst_m_tvalid", m_tvalid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_pkt_cnt", pkt_cnt, '0);
      check("rst_s_tready", s_tready, '0);
      check("rst_m_out", {m_tdata[31:0], m_tkeep, m_tlast, m_tuser, m_tid}, '0);

      // single 3-beat packet on input 0
      do_reset();
      load_pkt(0, 3, 1);
      plan(in_enable);
      drain("single", 50);
      check("single_beats", beats_seen, 3);
      check("single_span", last_cyc - first_cyc, 2);
      check("single_vld_cycles", valid_cycles, 3);
      check("single_busy_cycles", busy_cycles, 2);
      check("single_cnt0", pkt_cnt[31:0], 32'd1);
      check_counts("single");

      // round robin with both inputs offering two 2-beat packets
      do_reset();
      load_pkt(0, 2, 10);
      load_pkt(0, 2, 11);
      load_pkt(1, 2, 20);
      load_pkt(1, 2, 21);
      plan(in_enable);
      drain("rr", 60);
      check("rr_beats", beats_seen, 8);
      check("rr_span", last_cyc - first_cyc, 7);
      if (tid_log.size() == 8)
         check("rr_order", {tid_log[0][2:0], tid_log[1][2:0], tid_log[2][2:0], tid_log[3][2:0],
                            tid_log[4][2:0], tid_log[5][2:0], tid_log[6][2:0], tid_log[7][2:0]},
               {3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1});
      check("rr_cnt", pkt_cnt, {32'd2, 32'd2});
      check_counts("rr");

      // egress backpressure during a 4-beat packet
      do_reset();
      load_pkt(0, 4, 30);
      tr_pat.push_back(1'b1);
      tr_pat.push_back(1'b0);
      tr_pat.push_back(1'b0);
      tr_pat.push_back(1'b1);
      plan(in_enable);
      drain("bp", 60);
      check("bp_beats", beats_seen, 4);
      check("bp_stalls", stall_cnt, 2);
      check_counts("bp");

      // enable mask: only input 0 served; clearing its enable mid-packet still completes it
      do_reset();
      in_enable = 2'b01;
      load_pkt(0, 4, 40);
      load_pkt(1, 2, 41);
      plan(in_enable);
      n = 0;
      while (beats_seen < 2 && n < 50) begin
         step();
         n++;
      end
      check("en_mid_reached", beats_seen, 2);
      in_enable = 2'b00;
      drain("en", 60);
      repeat (5) step();
      check("en_beats", beats_seen, 4);
      check("en_rdy1_seen", tready1_seen, 1'b0);
      check("en_in1_left", src_q[1].size(), 2);
      check("en_idle", {busy, m_tvalid}, 2'b00);
      check_counts("en");
      in_enable = 2'b11;

      // counter wrap on input 1
      do_reset();
      force dut.cnt_q = {32'hFFFF_FFFF, 32'd0};
      step();
      release dut.cnt_q;
      exp_cnt[1] = 32'hFFFF_FFFF;
      check("wrap_preload", pkt_cnt[63:32], 32'hFFFF_FFFF);
      load_pkt(1, 1, 50);
      plan(in_enable);
      drain("wrap", 40);
      check("wrap_cnt1", pkt_cnt[63:32], 32'd0);
      check("wrap_idle", busy, 1'b0);
      check_counts("wrap");

      // reset in the middle of a 4-beat packet
      do_reset();
      load_pkt(0, 4, 60);
      plan(in_enable);
      n = 0;
      while (beats_seen < 1 && n < 50) begin
         step();
         n++;
      end
      check("mid_beat2_shown", {beats_seen[7:0], m_tvalid}, {8'd1, 1'b1});
      chk_en  = 1'b0;
      aresetn = 1'b0;
      #1;
      check("mid_rst_vld", m_tvalid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_cnt", pkt_cnt, '0);
      check("mid_rst_rdy", s_tready, '0);
      do_reset();
      load_pkt(1, 1, 70);
      plan(in_enable);
      drain("after_rst1", 40);
      if (tid_log.size() > 0) check("after_rst_in1", tid_log[0], 1);
      else check("after_rst_in1_beats", beats_seen, 1);
      do_reset();
      load_pkt(0, 1, 71);
      load_pkt(1, 1, 72);
      plan(in_enable);
      drain("after_rst2", 40);
      if (tid_log.size() > 0) check("after_rst_in0_first", tid_log[0], 0);
      else check("after_rst_both_beats", beats_seen, 2);
      check_counts("after_rst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
